// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared register-file definitions: default widths, enable constants and
// the round-robin pointer advance helper used by the write-back arbiter.
package regfile_wb_arbiter_pkg;

   localparam int unsigned RF_DATA_W = 32'd32;
   localparam int unsigned RF_ADDR_W = 32'd5;

   typedef enum logic {
      DISABLE = 1'b0,
      ENABLE  = 1'b1
   } rf_enable_e;

   function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
      if (idx + 32'd1 >= n) begin
         return 32'd0;
      end else begin
         return idx + 32'd1;
      end
   endfunction

endpackage

// File: rtl/regfile_wb_arbiter_rr_pick.sv
// Round-robin picker: first set request at or after ptr, wrapping around.
module regfile_wb_arbiter_rr_pick #(
   parameter int unsigned NREQ  = 32'd4,
   parameter int unsigned IDX_W = 32'd2
) (
   input  logic [NREQ-1:0]  req,
   input  logic [IDX_W-1:0] ptr,
   output logic [NREQ-1:0]  grant,
   output logic [IDX_W-1:0] idx,
   output logic             found
);

   // search from the pointer position, first hit wins
   always_comb begin
      int unsigned pos;
      grant = '0;
      idx   = '0;
      found = 1'b0;
      pos   = 32'd0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         pos = (32'(ptr) + i) % NREQ;
         if (!found && req[pos]) begin
            found      = 1'b1;
            grant[pos] = 1'b1;
            idx        = IDX_W'(pos);
         end else begin
            found = found;
         end
      end
   end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter: grants up to WRITE requesters per cycle onto the
// register file write ports, never two writes to one address together.
module regfile_wb_arbiter
   import regfile_wb_arbiter_pkg::*;
#(
   parameter int unsigned DATA     = RF_DATA_W,
   parameter int unsigned ADDR     = RF_ADDR_W,
   parameter int unsigned NREQ     = 32'd4,
   parameter int unsigned WRITE    = 32'd1,
   parameter rf_enable_e  ZERO_REG = DISABLE
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [NREQ-1:0]             req_valid,
   input  logic [NREQ-1:0][ADDR-1:0]   req_addr,
   input  logic [NREQ-1:0][DATA-1:0]   req_data,
   output logic [NREQ-1:0]             req_ready,
   input  logic                        flush,
   output logic [WRITE-1:0][ADDR-1:0]  waddr,
   output logic [WRITE-1:0]            we_,
   output logic [WRITE-1:0][DATA-1:0]  wdata
);

   localparam int unsigned IDX_W = (NREQ > 32'd1) ? $clog2(NREQ) : 32'd1;

   logic [IDX_W-1:0]            ptr_r;
   logic [IDX_W-1:0]            next_ptr_s;
   logic [IDX_W-1:0]            last_idx_s;
   logic                        any_grant_s;
   logic [WRITE-1:0]            port_we_s;
   logic [WRITE-1:0][ADDR-1:0]  port_addr_s;
   logic [WRITE-1:0][DATA-1:0]  port_data_s;

   for (genvar k = 0; k < WRITE; k++) begin : g_port
      logic [NREQ-1:0]  avail_in_s;
      logic [NREQ-1:0]  grant_s;
      logic [NREQ-1:0]  prev_ready_s;
      logic [NREQ-1:0]  ready_acc_s;
      logic [IDX_W-1:0] idx_s;
      logic [IDX_W-1:0] prev_last_s;
      logic [IDX_W-1:0] last_s;
      logic             found_s;
      logic             prev_any_s;
      logic             any_s;

      if (k == 0) begin : g_first
         assign avail_in_s   = (reset || flush) ? '0 : req_valid;
         assign prev_ready_s = '0;
         assign prev_last_s  = '0;
         assign prev_any_s   = 1'b0;
      end else begin : g_next
         // drop the previous winner and everything sharing its address
         always_comb begin
            avail_in_s = '0;
            for (int unsigned j = 0; j < NREQ; j++) begin
               avail_in_s[j] = g_port[k-1].avail_in_s[j] && !g_port[k-1].grant_s[j] &&
                               !(g_port[k-1].found_s &&
                                 (req_addr[j] == req_addr[g_port[k-1].idx_s]));
            end
         end
         assign prev_ready_s = g_port[k-1].ready_acc_s;
         assign prev_last_s  = g_port[k-1].last_s;
         assign prev_any_s   = g_port[k-1].any_s;
      end

      regfile_wb_arbiter_rr_pick #(
         .NREQ  (NREQ),
         .IDX_W (IDX_W)
      ) u_rr_pick (
         .req   (avail_in_s),
         .ptr   (ptr_r),
         .grant (grant_s),
         .idx   (idx_s),
         .found (found_s)
      );

      assign ready_acc_s = prev_ready_s | grant_s;
      assign last_s      = found_s ? idx_s : prev_last_s;
      assign any_s       = prev_any_s | found_s;

      // a zero-register grant still uses the port but never writes
      assign port_we_s[k]   = ~(found_s &&
                                !((ZERO_REG == ENABLE) && (req_addr[idx_s] == '0)));
      assign port_addr_s[k] = req_addr[idx_s];
      assign port_data_s[k] = req_data[idx_s];

      if (k == WRITE - 1) begin : g_last
         assign req_ready   = ready_acc_s;
         assign last_idx_s  = last_s;
         assign any_grant_s = any_s;
      end
   end

   // pointer advances past the last winner, holds otherwise
   always_comb begin
      if (any_grant_s) begin
         next_ptr_s = IDX_W'(rr_next(32'(last_idx_s), NREQ));
      end else begin
         next_ptr_s = ptr_r;
      end
   end

   // pointer and registered write ports; address/data hold when idle
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ptr_r <= '0;
         we_   <= '1;
         waddr <= '0;
         wdata <= '0;
      end else begin
         ptr_r <= next_ptr_s;
         we_   <= port_we_s;
         for (int k = 0; k < WRITE; k++) begin
            if (!port_we_s[k]) begin
               waddr[k] <= port_addr_s[k];
               wdata[k] <= port_data_s[k];
            end
         end
      end
   end

endmodule
